// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types, constants and helpers for the decimal arithmetic unit.
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [4:0] BCD_TEN = 5'd10;
  typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;
  function automatic logic digit_ok(input logic [3:0] d);
    return d <= BCD_NINE;
  endfunction
endpackage

// File: rtl/bcd_digit_adder.sv
// bcd_digit_adder: one-digit BCD adder with +6 decimal correction.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] t;
  always_comb begin
    t = {1'b0, x} + {1'b0, y} + {4'b0, cin};
    cout = t >= BCD_TEN;
    s = cout ? t[3:0] + 4'd6 : t[3:0];
  end
endmodule

// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor: digit-serial |a - b| on packed BCD via ten's complement, with sign and error flags.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [DIGIT_W*DIGITS-1:0] diff,
  output logic                    neg,
  output logic                    err
);
  localparam int W = DIGIT_W * DIGITS;
  localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  state_t state;
  logic [W-1:0] sa, sb, res, res_next;
  logic [CW-1:0] cnt;
  logic carry, valid, last, s_cout;
  logic [3:0] x, y, s;
  always_comb begin
    valid = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      valid = valid & digit_ok(a[i*DIGIT_W +: DIGIT_W]) & digit_ok(b[i*DIGIT_W +: DIGIT_W]);
  end
  assign last = cnt == CW'(DIGITS - 1);
  // FIX re-complements the result in place, so it feeds back the low result digit.
  assign x = state == FIX ? BCD_NINE - res[3:0] : sa[3:0];
  assign y = state == FIX ? 4'd0 : BCD_NINE - sb[3:0];
  assign res_next = (res >> DIGIT_W) | (W'(s) << (W - DIGIT_W));
  bcd_digit_adder u_add (
    .x   (x),
    .y   (y),
    .cin (carry),
    .s   (s),
    .cout(s_cout)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      res <= '0;
      cnt <= '0;
      carry <= 1'b0;
      neg <= 1'b0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sa <= a;
          sb <= b;
          cnt <= '0;
          carry <= 1'b1;
          neg <= 1'b0;
          err <= !valid;
          if (!valid) res <= '0;
          state <= valid ? SUB : DONE;
        end
        SUB: begin
          sa <= sa >> DIGIT_W;
          sb <= sb >> DIGIT_W;
          res <= res_next;
          cnt <= last ? '0 : cnt + 1'b1;
          carry <= last ? 1'b1 : s_cout;
          if (last) begin
            neg <= !s_cout;
            state <= s_cout ? DONE : FIX;
          end
        end
        FIX: begin
          res <= res_next;
          cnt <= last ? '0 : cnt + 1'b1;
          carry <= s_cout;
          if (last) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign diff = res;
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule
